// File: rtl/alu_operand_stage.sv
// Execute-entry stage: resolves ALU operands from the register file, the immediate
// or the EX/MEM/WB forwarding paths, and stalls on load-use hazards.
module alu_operand_stage #(
    parameter int XLEN = 64,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_alu_sel,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_wen,
    input  logic            in_is_load,
    input  logic [XLEN-1:0] alu_result,
    input  logic            fwd_mem_valid,
    input  logic [RW-1:0]   fwd_mem_rd,
    input  logic            fwd_mem_is_load,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_valid,
    input  logic [RW-1:0]   fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_sel,
    output logic [XLEN-1:0] src1,
    output logic [XLEN-1:0] src2,
    output logic [RW-1:0]   out_rd,
    output logic            out_wen,
    output logic            out_is_load
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // valid never waits on ready, and held payloads stay bit-stable until the transfer.

    logic            ex_alu;
    logic            ex_load;
    logic            mem_alu;
    logic            mem_load;
    logic            hazard;
    logic [XLEN-1:0] src1_next;
    logic [XLEN-1:0] src2_next;

    assign ex_alu   = out_valid && out_wen && !out_is_load;
    assign ex_load  = out_valid && out_wen && out_is_load;
    assign mem_alu  = fwd_mem_valid && !fwd_mem_is_load;
    assign mem_load = fwd_mem_valid && fwd_mem_is_load;

    function automatic logic [XLEN-1:0] resolve(
        input logic [RW-1:0]   rs,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_v,
        input logic [RW-1:0]   ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_v,
        input logic [RW-1:0]   mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_v,
        input logic [RW-1:0]   wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] val;
        if (rs == '0)                       val = '0;
        else if (ex_v && ex_rd == rs)       val = ex_data;
        else if (mem_v && mem_rd == rs)     val = mem_data;
        else if (wb_v && wb_rd == rs)       val = wb_data;
        else                                val = rf_val;
        return val;
    endfunction

    // A load still in EX or MEM has no data yet, so a consumer must wait for WB.
    function automatic logic load_dep(
        input logic [RW-1:0] rs,
        input logic          ex_v,
        input logic [RW-1:0] ex_rd,
        input logic          mem_v,
        input logic [RW-1:0] mem_rd
    );
        return (rs != '0) && ((ex_v && ex_rd == rs) || (mem_v && mem_rd == rs));
    endfunction

    always_comb begin
        hazard = load_dep(in_rs1, ex_load, out_rd, mem_load, fwd_mem_rd) ||
                 (!in_use_imm && load_dep(in_rs2, ex_load, out_rd, mem_load, fwd_mem_rd));
        src1_next = resolve(in_rs1, in_rs1_val, ex_alu, out_rd, alu_result,
                            mem_alu, fwd_mem_rd, fwd_mem_data,
                            fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        src2_next = in_use_imm ? in_imm :
                    resolve(in_rs2, in_rs2_val, ex_alu, out_rd, alu_result,
                            mem_alu, fwd_mem_rd, fwd_mem_data,
                            fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    end

    assign in_ready = rst_n && !flush && !hazard && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_sel     <= '0;
            src1        <= '0;
            src2        <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_is_load <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            alu_sel     <= in_alu_sel;
            src1        <= src1_next;
            src2        <= src2_next;
            out_rd      <= in_rd;
            out_wen     <= in_wen;
            out_is_load <= in_is_load;
        end else if (out_ready || !out_valid) begin
            // Nothing captured while the held instruction leaves: emit a bubble.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed test-plan scenarios plus random traffic,
// checked against a reference model through an expected-output queue.
module tb_alu_operand_stage;

    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int W    = 4 + XLEN + XLEN + RW + 1 + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_alu_sel;
    logic [RW-1:0]   in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm;
    logic            in_use_imm, in_wen, in_is_load;
    logic [XLEN-1:0] alu_result;
    logic            fwd_mem_valid, fwd_mem_is_load;
    logic [RW-1:0]   fwd_mem_rd;
    logic [XLEN-1:0] fwd_mem_data;
    logic            fwd_wb_valid;
    logic [RW-1:0]   fwd_wb_rd;
    logic [XLEN-1:0] fwd_wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] src1, src2;
    logic [RW-1:0]   out_rd;
    logic            out_wen, out_is_load;

    alu_operand_stage #(.XLEN(XLEN), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_sel(in_alu_sel), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
        .alu_result(alu_result), .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd),
        .fwd_mem_is_load(fwd_mem_is_load), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel),
        .src1(src1), .src2(src2), .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    typedef struct {
        logic            rst_n, valid, use_imm, wen, is_load, flush, out_ready;
        logic [3:0]      sel;
        logic [RW-1:0]   rs1, rs2, rd;
        logic [XLEN-1:0] rf1, rf2, imm, alu_res;
        logic            mem_v, mem_ld, wb_v;
        logic [RW-1:0]   mem_rd, wb_rd;
        logic [XLEN-1:0] mem_d, wb_d;
    } stim_t;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the held instruction (what the stage should contain).
    logic          m_valid = 1'b0, m_wen = 1'b0, m_is_load = 1'b0;
    logic [RW-1:0] m_rd = '0;
    logic          clear_q = 1'b0, chk_reset = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Producers listed in priority order; the first one holding rs supplies the value.
    function automatic logic [XLEN-1:0] model_fwd(input logic [RW-1:0] rs,
                                                  input logic [XLEN-1:0] rf_val, input stim_t s);
        logic            hit[4];
        logic [XLEN-1:0] val[4];
        logic [XLEN-1:0] r;
        hit[0] = (rs == 0);                                        val[0] = '0;
        hit[1] = m_valid && m_wen && !m_is_load && m_rd == rs;     val[1] = s.alu_res;
        hit[2] = s.mem_v && !s.mem_ld && s.mem_rd == rs;           val[2] = s.mem_d;
        hit[3] = s.wb_v && s.wb_rd == rs;                          val[3] = s.wb_d;
        r = rf_val;
        for (int i = 3; i >= 0; i--) if (hit[i]) r = val[i];
        return r;
    endfunction

    function automatic logic model_stall(input logic [RW-1:0] rs, input stim_t s);
        if (rs == 0) return 1'b0;
        return (m_valid && m_wen && m_is_load && m_rd == rs) ||
               (s.mem_v && s.mem_ld && s.mem_rd == rs);
    endfunction

    // ---------------- driver ----------------
    function automatic stim_t idle_stim();
        stim_t s;
        s.rst_n = 1; s.valid = 0; s.use_imm = 0; s.wen = 0; s.is_load = 0;
        s.flush = 0; s.out_ready = 1; s.sel = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
        s.rf1 = 0; s.rf2 = 0; s.imm = 0; s.alu_res = 0;
        s.mem_v = 0; s.mem_ld = 0; s.wb_v = 0; s.mem_rd = 0; s.wb_rd = 0;
        s.mem_d = 0; s.wb_d = 0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle_stim();
        s.valid   = $urandom_range(0, 3) != 0;
        s.sel     = 4'($urandom_range(0, 9));
        s.rs1     = RW'($urandom_range(0, 7));
        s.rs2     = RW'($urandom_range(0, 7));
        s.rd      = RW'($urandom_range(0, 7));
        s.rf1     = {$urandom, $urandom};
        s.rf2     = {$urandom, $urandom};
        s.imm     = {$urandom, $urandom};
        s.alu_res = {$urandom, $urandom};
        s.use_imm = 1'($urandom_range(0, 1));
        s.wen     = $urandom_range(0, 4) != 0;
        s.is_load = $urandom_range(0, 3) == 0;
        s.mem_v   = 1'($urandom_range(0, 1));
        s.mem_ld  = $urandom_range(0, 2) == 0;
        s.mem_rd  = RW'($urandom_range(0, 7));
        s.mem_d   = {$urandom, $urandom};
        s.wb_v    = 1'($urandom_range(0, 1));
        s.wb_rd   = RW'($urandom_range(0, 7));
        s.wb_d    = {$urandom, $urandom};
        s.flush   = $urandom_range(0, 19) == 0;
        s.out_ready = $urandom_range(0, 3) != 0;
        return s;
    endfunction

    // Called 1 time unit after a rising edge; returns at the same point of the next cycle.
    task automatic step(input stim_t s);
        logic            hz, er;
        logic [XLEN-1:0] e1, e2;
        if (clear_q) begin
            exp_q.delete();
            clear_q = 0;
        end
        rst_n = s.rst_n; in_valid = s.valid; in_alu_sel = s.sel;
        in_rs1 = s.rs1; in_rs2 = s.rs2; in_rs1_val = s.rf1; in_rs2_val = s.rf2;
        in_imm = s.imm; in_use_imm = s.use_imm; in_rd = s.rd; in_wen = s.wen;
        in_is_load = s.is_load; alu_result = s.alu_res;
        fwd_mem_valid = s.mem_v; fwd_mem_rd = s.mem_rd; fwd_mem_is_load = s.mem_ld;
        fwd_mem_data = s.mem_d; fwd_wb_valid = s.wb_v; fwd_wb_rd = s.wb_rd;
        fwd_wb_data = s.wb_d; flush = s.flush; out_ready = s.out_ready;

        hz = model_stall(s.rs1, s) || (!s.use_imm && model_stall(s.rs2, s));
        er = s.rst_n && !s.flush && !hz && (!m_valid || s.out_ready);
        e1 = model_fwd(s.rs1, s.rf1, s);
        e2 = s.use_imm ? s.imm : model_fwd(s.rs2, s.rf2, s);

        @(negedge clk);
        #1;
        chk("in_ready", W'(in_ready), W'(er));
        chk("out_valid", W'(out_valid), W'(m_valid));
        if (chk_reset) begin
            chk("reset_outputs", {alu_sel, src1, src2, out_rd, out_wen, out_is_load}, '0);
            chk_reset = 0;
        end

        if (!s.rst_n) begin
            m_valid = 0; m_wen = 0; m_is_load = 0; m_rd = 0;
            clear_q = 1; chk_reset = 1;
        end else if (s.flush) begin
            if (m_valid && !s.out_ready) void'(exp_q.pop_back());
            m_valid = 0;
        end else if (s.valid && er) begin
            exp_q.push_back({s.sel, e1, e2, s.rd, s.wen, s.is_load});
            m_valid = 1; m_rd = s.rd; m_wen = s.wen; m_is_load = s.is_load;
        end else if (s.out_ready || !m_valid) begin
            m_valid = 0;
        end

        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected no output",
                         {alu_sel, src1, src2, out_rd, out_wen, out_is_load});
            end else begin
                chk("held_output", {alu_sel, src1, src2, out_rd, out_wen, out_is_load}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        s = idle_stim();
        rst_n = 0; in_valid = 0; in_alu_sel = 0; in_rs1 = 0; in_rs2 = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_use_imm = 0; in_rd = 0;
        in_wen = 0; in_is_load = 0; alu_result = 0; fwd_mem_valid = 0; fwd_mem_rd = 0;
        fwd_mem_is_load = 0; fwd_mem_data = 0; fwd_wb_valid = 0; fwd_wb_rd = 0;
        fwd_wb_data = 0; flush = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset = 1;

        // Basic add with immediate.
        s = idle_stim(); s.valid = 1; s.rs1 = 1; s.rf1 = 5; s.imm = 7; s.use_imm = 1;
        s.rd = 2; s.wen = 1;
        step(s);
        step(idle_stim());

        // Back-to-back dependency through the EX forward.
        s = idle_stim(); s.valid = 1; s.rd = 3; s.wen = 1; s.rs1 = 1; s.rf1 = 1;
        step(s);
        s = idle_stim(); s.valid = 1; s.rs1 = 3; s.rf1 = 64'h99; s.alu_res = 64'h10;
        s.use_imm = 1; s.imm = 1; s.rd = 5; s.wen = 1;
        step(s);
        step(idle_stim());

        // MEM beats WB; r0 ignores both.
        s = idle_stim(); s.valid = 1; s.rs2 = 4; s.rf2 = 64'h55; s.sel = 4'd4;
        s.mem_v = 1; s.mem_rd = 4; s.mem_d = 64'hA; s.wb_v = 1; s.wb_rd = 4; s.wb_d = 64'hB;
        step(s);
        s.rs2 = 0;
        step(s);
        step(idle_stim());

        // Load-use: two bubbles, then WB forward. Same with use_imm: no stall.
        for (int pass = 0; pass < 2; pass++) begin
            s = idle_stim(); s.valid = 1; s.rd = 6; s.wen = 1; s.is_load = 1; s.rs1 = 2;
            step(s);
            s = idle_stim(); s.valid = 1; s.rs2 = 6; s.rf2 = 64'h77; s.use_imm = pass[0];
            s.imm = 64'h3; s.rd = 7; s.wen = 1; s.sel = 4'd1;
            step(s);
            s.mem_v = 1; s.mem_rd = 6; s.mem_ld = 1;
            step(s);
            s.mem_v = 0; s.wb_v = 1; s.wb_rd = 6; s.wb_d = 64'h1234;
            step(s);
            step(idle_stim());
        end

        // Backpressure for three cycles, then release.
        s = idle_stim(); s.valid = 1; s.rs1 = 1; s.rf1 = 64'hDEAD; s.rd = 1; s.wen = 1;
        step(s);
        s.rf1 = 64'hBEEF; s.out_ready = 0;
        repeat (3) step(s);
        s.out_ready = 1;
        step(s);
        step(idle_stim());

        // Flush during a load-use stall.
        s = idle_stim(); s.valid = 1; s.rd = 6; s.wen = 1; s.is_load = 1;
        step(s);
        s = idle_stim(); s.valid = 1; s.rs1 = 6; s.rd = 2; s.wen = 1;
        step(s);
        s.flush = 1; s.mem_v = 1; s.mem_rd = 6; s.mem_ld = 1;
        step(s);
        step(idle_stim());

        // Reset while an instruction is held under backpressure.
        s = idle_stim(); s.valid = 1; s.rs1 = 3; s.rf1 = 64'hF00D; s.rd = 3; s.wen = 1;
        s.sel = 4'd9;
        step(s);
        s.valid = 0; s.out_ready = 0;
        step(s);
        s.rst_n = 0;
        step(s);
        step(idle_stim());

        // Random traffic.
        for (int i = 0; i < 3000; i++) step(rand_stim());

        repeat (3) step(idle_stim());
        chk("queue_drained", W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
